alu_mc: RTL and testbench



---
 rtl/alu_mc.sv | 234 +++++++++++++++++++++++
 tb/tb_alu_mc.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// alu_mc: EX-stage ALU with single-cycle logic/shift/compare ops and an
// iterative shift-add multiplier / restoring divider for the RV32M group.
// Every output is registered; the iterative engine runs one bit per cycle.
module alu_mc #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     ready,
    input  logic                     kill,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     out_valid,
    output logic [DATA_WIDTH-1:0]    ALUResult,
    output logic                     Zero
);

    localparam int W  = DATA_WIDTH;
    localparam int SW = $clog2(W);
    localparam int CW = SW + 1;

    typedef logic [OPCODE_LENGTH-1:0] op_t;

    localparam op_t OP_AND    = op_t'(5'b00000);
    localparam op_t OP_OR     = op_t'(5'b00001);
    localparam op_t OP_ADD    = op_t'(5'b00010);
    localparam op_t OP_SUB    = op_t'(5'b00011);
    localparam op_t OP_XOR    = op_t'(5'b00100);
    localparam op_t OP_SLL    = op_t'(5'b00101);
    localparam op_t OP_SRL    = op_t'(5'b00110);
    localparam op_t OP_SRA    = op_t'(5'b00111);
    localparam op_t OP_EQ     = op_t'(5'b01000);
    localparam op_t OP_SLT    = op_t'(5'b01001);
    localparam op_t OP_SLTU   = op_t'(5'b01010);
    localparam op_t OP_DIV    = op_t'(5'b10100);
    localparam op_t OP_DIVU   = op_t'(5'b10101);
    localparam op_t OP_REM    = op_t'(5'b10110);
    localparam op_t OP_REMU   = op_t'(5'b10111);

    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;

    // Iterative engine: {high, low} accumulator plus the multiplicand/divisor
    // magnitude and the result-shaping flags captured at accept.
    logic [2*W-1:0]  acc;
    logic [W-1:0]    dvs;
    logic            mul_q;
    logic            hi_q;
    logic            rem_q;
    logic            neg_q;

    // Single-cycle result, including the two division corner cases that never
    // enter the engine (divide by zero, most-negative / -1).
    function automatic logic [W-1:0] fast_op(input op_t op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic signed [W-1:0] as;
        logic signed [W-1:0] bs;
        logic [SW-1:0]       sh;
        logic [W-1:0]        r;
        as = a;
        bs = b;
        sh = b[SW-1:0];
        r  = '0;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_XOR:  r = a ^ b;
            OP_SLL:  r = a << sh;
            OP_SRL:  r = a >> sh;
            OP_SRA:  r = as >>> sh;
            OP_EQ:   r = {{(W-1){1'b0}}, (a == b)};
            OP_SLT:  r = {{(W-1){1'b0}}, (as < bs)};
            OP_SLTU: r = {{(W-1){1'b0}}, (a < b)};
            OP_DIV,
            OP_DIVU: r = (b == '0) ? {W{1'b1}} : MOST_NEG;
            OP_REM,
            OP_REMU: r = (b == '0) ? a : '0;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Turn the unsigned engine output into the architectural result: pick the
    // product half or quotient/remainder and reapply the sign removed at accept.
    function automatic logic [W-1:0] sign_fix(input logic [2*W-1:0] a,
                                              input logic mul,
                                              input logic hi,
                                              input logic rem,
                                              input logic neg);
        logic [2*W-1:0] p;
        logic [W-1:0]   v;
        if (mul) begin
            p = neg ? -a : a;
            v = hi ? p[2*W-1:W] : p[W-1:0];
        end else begin
            v = rem ? a[2*W-1:W] : a[W-1:0];
            if (neg) v = -v;
        end
        return v;
    endfunction

    logic           accept;
    logic           is_mul;
    logic           is_div;
    logic           div_signed;
    logic           div_zero;
    logic           div_ovf;
    logic           go_iter;
    logic           a_sgn;
    logic           b_sgn;
    logic           neg_res;
    logic [W-1:0]   mag_a;
    logic [W-1:0]   mag_b;
    logic [W-1:0]   fast_res;
    logic [W:0]     mul_sum;
    logic [W:0]     div_trial;
    logic [2*W-1:0] mul_nxt;
    logic [2*W-1:0] div_nxt;
    logic [2*W-1:0] acc_nxt;
    logic [W-1:0]   iter_res;

    // Request decode and operand conditioning at the accept edge.
    always_comb begin
        accept     = in_valid & ready;
        is_mul     = (Operation[4:2] == 3'b100);
        is_div     = (Operation[4:2] == 3'b101);
        div_signed = is_div & ~Operation[0];
        div_zero   = (SrcB == '0);
        div_ovf    = div_signed & (SrcA == MOST_NEG) & (SrcB == {W{1'b1}});
        go_iter    = is_mul | (is_div & ~div_zero & ~div_ovf);

        // MUL/MULH/MULHSU treat A as signed, MUL/MULH treat B as signed.
        a_sgn   = (is_mul ? (Operation[1:0] != 2'b11) : div_signed) & SrcA[W-1];
        b_sgn   = (is_mul ? ~Operation[1]             : div_signed) & SrcB[W-1];
        mag_a   = a_sgn ? -SrcA : SrcA;
        mag_b   = b_sgn ? -SrcB : SrcB;
        // Remainder follows the dividend; product and quotient follow A xor B.
        neg_res = (is_div & Operation[1]) ? a_sgn : (a_sgn ^ b_sgn);

        fast_res = fast_op(Operation, SrcA, SrcB);
    end

    // One engine step: shift-add multiply or restoring-divide iteration.
    always_comb begin
        mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, dvs} : {(W+1){1'b0}});
        mul_nxt   = {mul_sum, acc[W-1:1]};
        div_trial = acc[2*W-1:W-1] - {1'b0, dvs};
        div_nxt   = div_trial[W] ? {acc[2*W-2:0], 1'b0}
                                 : {div_trial[W-1:0], acc[W-2:0], 1'b1};
        acc_nxt   = mul_q ? mul_nxt : div_nxt;
        iter_res  = sign_fix(acc_nxt, mul_q, hi_q, rem_q, neg_q);
    end

    // Engine datapath: load magnitudes on accept, iterate while busy.
    always_ff @(posedge clk) begin
        if (accept && go_iter) begin
            acc   <= {{W{1'b0}}, mag_a};
            dvs   <= mag_b;
            mul_q <= is_mul;
            hi_q  <= (Operation[1:0] != 2'b00);
            rem_q <= Operation[1];
            neg_q <= neg_res;
        end else if (state == BUSY) begin
            acc   <= acc_nxt;
        end
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            ready     <= 1'b1;
            out_valid <= 1'b0;
            ALUResult <= '0;
            Zero      <= 1'b1;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (accept) begin
                        if (go_iter) begin
                            state <= BUSY;
                            ready <= 1'b0;
                            cnt   <= CW'(W);
                        end else begin
                            ALUResult <= fast_res;
                            Zero      <= (fast_res == '0);
                            out_valid <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (kill) begin
                        state <= IDLE;
                        ready <= 1'b1;
                        cnt   <= '0;
                    end else if (cnt == CW'(1)) begin
                        // Last iteration: the fixed-up result lands with DONE.
                        state     <= DONE;
                        ready     <= 1'b1;
                        cnt       <= '0;
                        ALUResult <= iter_res;
                        Zero      <= (iter_res == '0);
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed and randomized checks of alu_mc against a 64-bit
// arithmetic reference model, including latency, kill and reset behaviour.
module tb_alu_mc;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          kill = 1'b0;
    logic [W-1:0]  SrcA = '0;
    logic [W-1:0]  SrcB = '0;
    logic [4:0]    Operation = '0;
    logic          ready;
    logic          out_valid;
    logic [W-1:0]  ALUResult;
    logic          Zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_mc #(.DATA_WIDTH(W), .OPCODE_LENGTH(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .ready     (ready),
        .kill      (kill),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .Operation (Operation),
        .out_valid (out_valid),
        .ALUResult (ALUResult),
        .Zero      (Zero)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: RISC-V semantics computed with plain 64-bit arithmetic.
    function automatic logic [W-1:0] ref_alu(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        logic [W-1:0] r;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'h0, a};
        ub = {32'h0, b};
        r  = '0;
        case (op)
            5'd0:  r = a & b;
            5'd1:  r = a | b;
            5'd2:  r = a + b;
            5'd3:  r = a - b;
            5'd4:  r = a ^ b;
            5'd5:  r = a << b[4:0];
            5'd6:  r = a >> b[4:0];
            5'd7:  r = $signed(a) >>> b[4:0];
            5'd8:  r = (a == b) ? 32'd1 : 32'd0;
            5'd9:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd10: r = (a < b) ? 32'd1 : 32'd0;
            5'd16: begin p = sa * sb; r = p[31:0];  end
            5'd17: begin p = sa * sb; r = p[63:32]; end
            5'd18: begin p = sa * ub; r = p[63:32]; end
            5'd19: begin p = ua * ub; r = p[63:32]; end
            5'd20: r = (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
            5'd21: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'd22: r = (b == 0) ? a : 32'(sa % sb);
            5'd23: r = (b == 0) ? a : a % b;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Cycles from accept to out_valid: multiplies and non-special divides
    // take DATA_WIDTH+1, everything else one.
    function automatic int ref_lat(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bit ovf;
        ovf = (op == 5'd20 || op == 5'd22) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
        if (op >= 5'd16 && op <= 5'd19) return W + 1;
        if (op >= 5'd20 && op <= 5'd23 && b != 0 && !ovf) return W + 1;
        return 1;
    endfunction

    // Present a request at a falling edge and hold it until accepted.
    task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int waits;
        @(negedge clk);
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        in_valid  = 1'b1;
        waits     = 0;
        while (!ready && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        if (!ready) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [4:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp);
        int lat;
        bit stayed_low, early;
        lat        = ref_lat(op, a, b);
        stayed_low = 1'b1;
        early      = 1'b0;
        issue(op, a, b);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k < lat) begin
                if (ready) stayed_low = 1'b0;
                if (out_valid) early = 1'b1;
            end
        end
        check({tag, "_vld"},   {31'd0, out_valid}, 32'd1);
        check({tag, "_res"},   ALUResult, exp);
        check({tag, "_zero"},  {31'd0, Zero}, {31'd0, (exp == 0)});
        check({tag, "_ready"}, {31'd0, ready}, 32'd1);
        if (lat > 1) begin
            check({tag, "_busy"},  {31'd0, stayed_low}, 32'd1);
            check({tag, "_early"}, {31'd0, early}, 32'd0);
        end
    endtask

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]   fops [6];
        logic [W-1:0] fa   [6];
        logic [W-1:0] fb   [6];
        logic [W-1:0] fe   [6];
        logic [4:0]   rops [21];
        logic [4:0]   op;
        logic [W-1:0] a, b, e1, e2;
        int           pulses;
        bit           pending, acc_now, saw;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_vld",   {31'd0, out_valid}, 32'd0);
        check("rst_res",   ALUResult, 32'd0);
        check("rst_zero",  {31'd0, Zero}, 32'd1);
        rst_n = 1'b1;

        // Asynchronous reset in the middle of a multiply
        run_op("pre_rst", 5'd2, 32'd100, 32'd23, 32'd123);
        issue(5'd16, 32'd3, 32'd5);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ready", {31'd0, ready}, 32'd1);
        check("arst_vld",   {31'd0, out_valid}, 32'd0);
        check("arst_res",   ALUResult, 32'd0);
        check("arst_zero",  {31'd0, Zero}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("add57", 5'd2, 32'd5, 32'd7, 32'd12);

        // Back-to-back fast ops, one result per cycle
        fops = '{5'd3, 5'd7, 5'd9, 5'd10, 5'd8, 5'd5};
        fa   = '{32'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd9, 32'h0000_0003};
        fb   = '{32'd5, 32'd4, 32'd1, 32'd1, 32'd9, 32'd31};
        fe   = '{32'hFFFF_FFFE, 32'hF800_0000, 32'd1, 32'd0, 32'd1, 32'h8000_0000};
        for (int i = 0; i <= 6; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check($sformatf("b2b%0d_vld", i - 1), {31'd0, out_valid}, 32'd1);
                check($sformatf("b2b%0d_res", i - 1), ALUResult, fe[i-1]);
            end
            if (i < 6) begin
                Operation = fops[i];
                SrcA      = fa[i];
                SrcB      = fb[i];
                in_valid  = 1'b1;
            end else begin
                in_valid  = 1'b0;
            end
        end
        @(negedge clk);
        check("b2b_end_vld", {31'd0, out_valid}, 32'd0);

        // Multiply
        run_op("mulh_m1",  5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
        run_op("mulhu_m1", 5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("mul_7m3",  5'd16, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_op("mulhsu",   5'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // Divide and its special cases
        run_op("div_m7_2",  5'd20, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_op("rem_m7_2",  5'd22, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_op("divu_by0",  5'd21, 32'd7, 32'd0, 32'hFFFF_FFFF);
        run_op("remu_by0",  5'd23, 32'd7, 32'd0, 32'd7);
        run_op("div_ovf",   5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_ovf",   5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run_op("divu_big",  5'd21, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555);

        // Kill during an iterative divide
        run_op("pre_kill", 5'd2, 32'd1, 32'd1, 32'd2);
        issue(5'd21, 32'd1000, 32'd7);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 10) kill = 1'b1;
        end
        @(posedge clk);
        #1 kill = 1'b0;
        @(negedge clk);
        check("kill_ready", {31'd0, ready}, 32'd1);
        check("kill_vld",   {31'd0, out_valid}, 32'd0);
        check("kill_res",   ALUResult, 32'd2);
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) saw = 1'b1;
        end
        check("kill_no_vld", {31'd0, saw}, 32'd0);
        check("kill_hold",   ALUResult, 32'd2);

        // Kill while idle does not block a simultaneous accept
        kill = 1'b1;
        run_op("kill_idle", 5'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00);
        kill = 1'b0;

        // Request held through BUSY is taken in the DONE cycle
        e1 = ref_alu(5'd16, 32'd7, 32'hFFFF_FFFD);
        e2 = ref_alu(5'd16, 32'h0001_2345, 32'h0000_6789);
        @(negedge clk);
        Operation = 5'd16; SrcA = 32'd7; SrcB = 32'hFFFF_FFFD; in_valid = 1'b1;
        @(posedge clk);
        #1;
        SrcA = 32'h0001_2345; SrcB = 32'h0000_6789;
        pending = 1'b1;
        pulses  = 0;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            if (out_valid) begin
                pulses++;
                if (pulses == 1) begin
                    check("hs_t1",   32'(k), 32'd33);
                    check("hs_res1", ALUResult, e1);
                end else begin
                    check("hs_t2",   32'(k), 32'd66);
                    check("hs_res2", ALUResult, e2);
                end
            end
            acc_now = pending && ready;
            @(posedge clk);
            #1;
            if (acc_now) begin
                in_valid = 1'b0;
                pending  = 1'b0;
            end
        end
        in_valid = 1'b0;
        check("hs_pulses", 32'(pulses), 32'd2);

        // Randomized ops against the reference model
        rops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                 5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23, 5'd11, 5'd27};
        for (int i = 0; i < 50; i++) begin
            op = rops[$urandom_range(0, 20)];
            a  = rnd_operand();
            b  = rnd_operand();
            run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, ref_alu(op, a, b));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
